// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle plus the transmitter start/done handshake
// for the packet-level UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_byte;
  logic              tx_send;
  logic              tx_done;
  logic              abort;

  // Sources and the transmitter side.
  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, grant, tx_byte, tx_send, abort
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, grant, tx_byte, tx_send, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one 8N1 transmitter among NREQ byte
// streams; a grant is held until the message's last byte has been sent.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_STALL = 65535
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(MAX_STALL + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_winner_q, last_winner_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_send_q, tx_send_d;
  logic            abort_q, abort_d;
  logic            last_flag_q, last_flag_d;

  logic            rr_found;
  logic [IW-1:0]   rr_idx;
  logic [IW-1:0]   cand;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            handshake;

  // Round-robin pick: first requester at or after last_winner+1, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_winner_q) + k) % NREQ);
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_last = bus.req_last[i];
      end
    end
  end

  assign handshake     = (state_q == LOAD) && |(bus.req_valid & grant_q);
  assign bus.req_ready = (state_q == LOAD) ? (bus.req_valid & grant_q) : '0;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_winner_d = last_winner_q;
    stall_d       = stall_q;
    tx_byte_d     = tx_byte_q;
    last_flag_d   = last_flag_q;
    tx_send_d     = 1'b0;
    abort_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d         = '0;
          grant_d[rr_idx] = 1'b1;
          gidx_d          = rr_idx;
          stall_d         = '0;
          state_d         = LOAD;
        end
      end

      LOAD: begin
        if (handshake) begin
          tx_byte_d   = sel_data;
          last_flag_d = sel_last;
          tx_send_d   = 1'b1;
          stall_d     = '0;
          state_d     = WAIT;
        end else if (stall_q == STALL_MAX) begin
          // Source went quiet mid-message: drop it and let others in.
          abort_d       = 1'b1;
          grant_d       = '0;
          last_winner_d = gidx_q;
          stall_d       = '0;
          state_d       = IDLE;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end

      WAIT: begin
        if (bus.tx_done) begin
          if (last_flag_q) begin
            last_winner_d = gidx_q;
            grant_d       = '0;
            state_d       = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      last_winner_q <= IW'(NREQ - 1);
      stall_q       <= '0;
      tx_byte_q     <= 8'h00;
      last_flag_q   <= 1'b0;
      tx_send_q     <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      last_winner_q <= last_winner_d;
      stall_q       <= stall_d;
      tx_byte_q     <= tx_byte_d;
      last_flag_q   <= last_flag_d;
      tx_send_q     <= tx_send_d;
      abort_q       <= abort_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.tx_byte = tx_byte_q;
  assign bus.tx_send = tx_send_q;
  assign bus.abort   = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single message, fairness, no
// interleave, stall abort, spurious tx_done and reset mid-packet.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_STALL = 10;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] data, input logic last);
    bus.req_data[8*i +: 8] = data;
    bus.req_last[i]        = last;
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_done   = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_grant",   32'(bus.grant),     32'h0);
    check("rst_send",    32'(bus.tx_send),   32'h0);
    check("rst_abort",   32'(bus.abort),     32'h0);
    check("rst_byte",    32'(bus.tx_byte),   32'h00);
    check("rst_ready",   32'(bus.req_ready), 32'h0);

    // Single requester sends "Hi\r"
    set_req(0, 8'h48, 1'b0);
    bus.req_valid = 4'b0001;
    tick();
    check("hi_grant",    32'(bus.grant),     32'h1);
    check("hi_ready",    32'(bus.req_ready), 32'h1);
    tick();
    check("hi_send0",    32'(bus.tx_send),   32'h1);
    check("hi_byte0",    32'(bus.tx_byte),   32'h48);
    set_req(0, 8'h69, 1'b0);
    check("hi_wait_rdy", 32'(bus.req_ready), 32'h0);
    tick();
    check("hi_pulse1w",  32'(bus.tx_send),   32'h0);
    check("hi_hold",     32'(bus.tx_byte),   32'h48);
    do_done();
    check("hi_nosend",   32'(bus.tx_send),   32'h0);
    tick();
    check("hi_send1",    32'(bus.tx_send),   32'h1);
    check("hi_byte1",    32'(bus.tx_byte),   32'h69);
    set_req(0, 8'h0D, 1'b1);
    do_done();
    tick();
    check("hi_send2",    32'(bus.tx_send),   32'h1);
    check("hi_byte2",    32'(bus.tx_byte),   32'h0D);
    bus.req_valid = 4'b0000;
    tick();
    check("hi_held",     32'(bus.grant),     32'h1);
    do_done();
    check("hi_release",  32'(bus.grant),     32'h0);

    // Spurious tx_done in IDLE and in LOAD
    do_done();
    check("sp_idle_snd", 32'(bus.tx_send),   32'h0);
    check("sp_idle_gnt", 32'(bus.grant),     32'h0);
    set_req(1, 8'h55, 1'b1);
    bus.req_valid = 4'b0010;
    tick();
    check("sp_load_gnt", 32'(bus.grant),     32'h2);
    bus.req_valid = 4'b0000;
    do_done();
    check("sp_load_snd", 32'(bus.tx_send),   32'h0);
    check("sp_load_hld", 32'(bus.grant),     32'h2);
    bus.req_valid = 4'b0010;
    #1;
    check("sp_load_rdy", 32'(bus.req_ready), 32'h2);
    tick();
    check("sp_send",     32'(bus.tx_send),   32'h1);
    check("sp_byte",     32'(bus.tx_byte),   32'h55);
    bus.req_valid = 4'b0000;
    do_done();
    check("sp_release",  32'(bus.grant),     32'h0);

    // Fairness with four continuous one-byte requesters
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'hA0 + 8'(i), 1'b1);
    bus.req_valid = 4'b1111;
    for (int p = 0; p < 6; p++) begin
      tick();
      check("rr_grant",  32'(bus.grant),     32'(1) << exp_order[p]);
      tick();
      check("rr_byte",   32'(bus.tx_byte),   32'hA0 + 32'(exp_order[p]));
      do_done();
      check("rr_gap",    32'(bus.grant),     32'h0);
    end
    bus.req_valid = 4'b0000;

    // No interleave: requester 1 keeps the grant while 2 waits
    do_reset();
    set_req(1, 8'h31, 1'b0);
    set_req(2, 8'h77, 1'b1);
    bus.req_valid = 4'b0110;
    tick();
    check("ni_grant",    32'(bus.grant),     32'h2);
    check("ni_ready0",   32'(bus.req_ready), 32'h2);
    tick();
    check("ni_byte0",    32'(bus.tx_byte),   32'h31);
    set_req(1, 8'h32, 1'b0);
    check("ni_wait_rdy", 32'(bus.req_ready), 32'h0);
    do_done();
    check("ni_ready1",   32'(bus.req_ready), 32'h2);
    tick();
    check("ni_byte1",    32'(bus.tx_byte),   32'h32);
    set_req(1, 8'h33, 1'b1);
    do_done();
    tick();
    check("ni_byte2",    32'(bus.tx_byte),   32'h33);
    bus.req_valid = 4'b0100;
    do_done();
    check("ni_gap",      32'(bus.grant),     32'h0);
    check("ni_gap_rdy",  32'(bus.req_ready), 32'h0);
    tick();
    check("ni_next",     32'(bus.grant),     32'h4);
    tick();
    check("ni_byte_r2",  32'(bus.tx_byte),   32'h77);
    bus.req_valid = 4'b0000;
    do_done();

    // Stall abort: requester 3 goes quiet after a non-last byte
    do_reset();
    set_req(3, 8'h41, 1'b0);
    bus.req_valid = 4'b1000;
    tick();
    check("st_grant",    32'(bus.grant),     32'h8);
    tick();
    check("st_byte",     32'(bus.tx_byte),   32'h41);
    bus.req_valid = 4'b0000;
    do_done();
    for (int c = 0; c < 10; c++) tick();
    check("st_early",    32'(bus.abort),     32'h0);
    check("st_held",     32'(bus.grant),     32'h8);
    tick();
    check("st_abort",    32'(bus.abort),     32'h1);
    check("st_gnt0",     32'(bus.grant),     32'h0);
    set_req(0, 8'h10, 1'b1);
    set_req(2, 8'h20, 1'b0);
    bus.req_valid = 4'b0101;
    tick();
    check("st_pulse1w",  32'(bus.abort),     32'h0);
    check("st_next",     32'(bus.grant),     32'h1);

    // Reset mid-packet, then requester 0 must again beat 2
    tick();
    check("rm_byte0",    32'(bus.tx_byte),   32'h10);
    do_done();
    tick();
    check("rm_grant2",   32'(bus.grant),     32'h4);
    tick();
    check("rm_send",     32'(bus.tx_send),   32'h1);
    rst = 1'b1;
    tick();
    check("rm_grant",    32'(bus.grant),     32'h0);
    check("rm_send0",    32'(bus.tx_send),   32'h0);
    check("rm_abort",    32'(bus.abort),     32'h0);
    check("rm_byte",     32'(bus.tx_byte),   32'h00);
    check("rm_ready",    32'(bus.req_ready), 32'h0);
    rst = 1'b0;
    tick();
    check("rm_tie",      32'(bus.grant),     32'h1);
    bus.req_valid = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one 8N1 UART transmitter between NREQ byte-stream requesters. Each requester offers a message as a valid/ready byte stream with a last flag. The arbiter grants one requester at a time, holds the grant until that message's last byte has been transmitted, and paces bytes against the transmitter's start/done handshake. It sits between the message sources (status printers, keypad echo, debug dumps) and the uart_tx_8n1 instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- MAX_STALL, 65535, clk cycles a granted requester may hold req_valid low mid-message before its packet is aborted
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i offers a byte
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NREQ  bit i: offered byte is the last of the message
- req_ready  out  NREQ  bit i: byte of requester i accepted this cycle (valid & ready)
- grant  out  NREQ  one-hot owner of the transmitter, 0 when idle
- tx_byte  out  8  byte presented to the transmitter
- tx_send  out  1  one-cycle start pulse to the transmitter
- tx_done  in  1  one-cycle pulse: transmitter finished the current byte (stop bit sent)
- abort  out  1  one-cycle pulse: granted packet dropped on stall timeout

## Operation
- States: IDLE, LOAD, WAIT.
- IDLE: grant=0, req_ready=0. If any req_valid, pick the winner by round-robin. Search starts at (last_winner+1) mod NREQ and takes the first set bit. Register grant, go to LOAD. Clear stall counter.
- LOAD: req_ready[g] = req_valid[g] (combinational, only the granted bit); other bits 0.
  - On handshake: tx_byte <= req_data[g], last_flag <= req_last[g], tx_send pulses next cycle, go to WAIT, stall counter cleared.
  - Without handshake: stall counter increments. When it reaches MAX_STALL: abort pulse, grant cleared, last_winner <= g, go to IDLE.
- WAIT: req_ready=0. tx_byte held stable. On tx_done:
  - If last_flag: last_winner <= g, grant cleared, go to IDLE.
  - Else: go to LOAD.
- tx_done outside WAIT is ignored.
- Non-granted requesters see req_ready=0 for the whole packet. Bytes of different messages never interleave.
- Stall counter width is clog2(MAX_STALL+1). It saturates, never wraps.
- Reset: state IDLE; grant=0, req_ready=0, tx_send=0, abort=0, tx_byte=8'h00; last_winner=NREQ-1, so requester 0 has first priority.
- Reset asserted mid-packet discards the packet immediately. The transmitter is not notified; its in-flight byte completes on the line.

## Timing
- Request in IDLE at cycle n -> grant at n+1 (LOAD). Earliest handshake at n+1. tx_send high and tx_byte valid at n+2.
- tx_send is exactly one cycle wide, one pulse per accepted byte.
- tx_done at cycle m in WAIT:
  - Not last: LOAD at m+1; next handshake possible at m+1.
  - Last: IDLE at m+1; next grant at m+2 at the earliest.
- Inter-packet gap: at least one IDLE cycle between the last tx_done and the next grant.
- abort pulses in the cycle after the counter hits MAX_STALL. Grant is 0 in that same cycle.
- Simultaneous requests resolve in a single cycle. The granted requester is excluded from the next arbitration unless it is the only one requesting.

## Test plan
- Single requester: req 0 sends "Hi\r" with last on '\r'. Expect tx_send pulses carrying 0x48, 0x69, 0x0D. Each pulse follows the prior tx_done by 2 cycles. grant returns to 0 one cycle after the third tx_done.
- Fairness: all 4 request continuously with 1-byte messages. Grant order is 0,1,2,3,0,1. Requester 0 is first after reset.
- No interleave: req 1 sends a 3-byte message while req 2 is valid throughout. req_ready[2] stays 0 until the packet finishes; then grant=4'b0100.
- Stall abort: MAX_STALL=10; req 3 sends byte 0x41 (not last), then drops valid. abort pulses 11 cycles after the LOAD entry following tx_done. grant=0. Next arbitration starts at requester 0.
- Spurious tx_done: tx_done pulsed in IDLE and LOAD. No state change, no tx_send.
- Reset mid-packet: rst asserted during WAIT. Next cycle all outputs are 0 and state is IDLE. After release, requester 0 wins a tie with 2.
